fifo_rd_ctrl: RTL and testbench

Read-side controller for the async FIFO. It runs entirely in the read clock domain. It consumes the write pointer after it has been brought across by the pointer synchronizer, and sequences reads from the registered dual-port RAM. It presents a first-word-fall-through valid/ready stream to the consumer and publishes the Gray read pointer back toward the write domain, along with the empty and almost-empty flags.

---
 rtl/fifo_rd_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: issues RAM reads against the synchronized
// write pointer and presents a first-word-fall-through valid/ready stream.
module fifo_rd_ctrl #(
  parameter int ASIZE         = 4,
  parameter int DSIZE         = 8,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic [ASIZE:0]   rptr,
  output logic             ren,
  output logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] rdata_in,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  input  logic             rready,
  output logic             rempty,
  output logic             arempty
);

  localparam logic [ASIZE:0] PTR_ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AE_THRESH = (ASIZE+1)'(AEMPTY_THRESH);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  buf_state_t       buf_state_reg;
  logic [ASIZE:0]   rbin_reg;
  logic [ASIZE:0]   rptr_reg;
  logic             inflight_reg;
  logic [DSIZE-1:0] head_reg;
  logic [DSIZE-1:0] skid_reg;
  logic             rempty_reg;
  logic             arempty_reg;

  logic [ASIZE:0]   wbin;
  logic [ASIZE:0]   occ;
  logic [ASIZE:0]   occ_next;
  logic [ASIZE:0]   rbin_next;
  logic [ASIZE:0]   rgray_next;
  logic [1:0]       held;
  logic [2:0]       slots_used;
  logic             pop;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ASIZE; gi++) begin : g_g2b
      assign wbin[gi] = ^rq2_wptr[ASIZE:gi];
    end
  endgenerate

  always_comb begin
    held = 2'd0;
    case (buf_state_reg)
      BUF_ONE: held = 2'd1;
      BUF_TWO: held = 2'd2;
      default: held = 2'd0;
    endcase
  end

  assign rvalid = (buf_state_reg != BUF_EMPTY);
  assign pop    = rvalid && rready;
  assign occ    = wbin - rbin_reg;

  // A read is only issued if the buffer is guaranteed a slot when its data lands.
  assign slots_used = {1'b0, held} + {2'b00, inflight_reg} - {2'b00, pop};
  assign ren        = !rrst && (occ != '0) && (slots_used < 3'd2);

  assign rbin_next  = ren ? (rbin_reg + PTR_ONE) : rbin_reg;
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign occ_next   = wbin - rbin_next;

  assign raddr   = rbin_reg[ASIZE-1:0];
  assign rptr    = rptr_reg;
  assign rdata   = head_reg;
  assign rempty  = rempty_reg;
  assign arempty = arempty_reg;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_reg      <= '0;
      rptr_reg      <= '0;
      inflight_reg  <= 1'b0;
      buf_state_reg <= BUF_EMPTY;
      head_reg      <= '0;
      skid_reg      <= '0;
      rempty_reg    <= 1'b1;
      arempty_reg   <= 1'b1;
    end else begin
      rbin_reg     <= rbin_next;
      rptr_reg     <= rgray_next;
      inflight_reg <= ren;
      rempty_reg   <= (rq2_wptr == rgray_next);
      arempty_reg  <= (occ_next <= AE_THRESH);

      // Capture lands in the head whenever the head is free after this cycle's pop.
      case (buf_state_reg)
        BUF_EMPTY: begin
          if (inflight_reg) begin
            head_reg      <= rdata_in;
            buf_state_reg <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (inflight_reg && pop) begin
            head_reg <= rdata_in;
          end else if (inflight_reg) begin
            skid_reg      <= rdata_in;
            buf_state_reg <= BUF_TWO;
          end else if (pop) begin
            buf_state_reg <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          // A capture cannot coincide with this state; the issue rule forbids it.
          if (pop) begin
            head_reg      <= skid_reg;
            buf_state_reg <= BUF_ONE;
          end
        end
        default: buf_state_reg <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a behavioural writer and 1-cycle RAM feed the controller,
// a scoreboard queue holds written words and is checked on every pop.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic [4:0] rq2_wptr = '0;
  logic [4:0] rptr;
  logic       ren;
  logic [3:0] raddr;
  logic [7:0] rdata_in = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready = 1'b1;
  logic       rempty;
  logic       arempty;

  logic [7:0] mem [16];
  logic [4:0] wbin = '0;
  logic [7:0] sb_q [$];
  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8), .AEMPTY_THRESH(1)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rq2_wptr (rq2_wptr),
    .rptr     (rptr),
    .ren      (ren),
    .raddr    (raddr),
    .rdata_in (rdata_in),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .rempty   (rempty),
    .arempty  (arempty)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (ren) rdata_in <= mem[raddr];
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every accepted word must match the oldest written word.
  always @(negedge rclk) begin
    if (!rrst && rvalid && rready) begin
      if (sb_q.size() == 0) begin
        chk("extra_word", {31'd0, rvalid}, 32'd0);
      end else begin
        $display("pop data=%02h", rdata);
        chk("pop_data", {24'd0, rdata}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic put(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wbin[3:0]] = base + 8'(i);
      sb_q.push_back(base + 8'(i));
      wbin = wbin + 5'd1;
    end
    rq2_wptr = gray(wbin);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge rclk);
      if (sb_q.size() == 0 && !rvalid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'd0, done}, 32'd1);
    chk("drain_rempty", {31'd0, rempty}, 32'd1);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wbin = '0;
    rq2_wptr = '0;
    rready = 1'b1;
    sb_q.delete();
    tick();
    tick();
    rrst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] wexp [4];
    int nren;
    int k;

    // Reset held with a nonzero write pointer
    for (int i = 0; i < 5; i++) begin
      mem[i] = 8'h10 + 8'(i);
      sb_q.push_back(8'h10 + 8'(i));
    end
    wbin = 5'd5;
    rq2_wptr = gray(5'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge rclk);
      chk("rst_ren", {31'd0, ren}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rptr", {27'd0, rptr}, 32'd0);
      chk("rst_rempty", {31'd0, rempty}, 32'd1);
      chk("rst_arempty", {31'd0, arempty}, 32'd1);
    end
    tick();
    rrst = 1'b0;
    @(negedge rclk);
    chk("rel_ren", {31'd0, ren}, 32'd1);
    drain();

    // Single word, latency 2
    do_reset();
    tick();
    put(1, 8'hA5);
    @(negedge rclk);
    chk("sw_ren0", {31'd0, ren}, 32'd1);
    chk("sw_raddr0", {28'd0, raddr}, 32'd0);
    tick();
    @(negedge rclk);
    chk("sw_ren1", {31'd0, ren}, 32'd0);
    chk("sw_rvalid1", {31'd0, rvalid}, 32'd0);
    chk("sw_rempty1", {31'd0, rempty}, 32'd1);
    chk("sw_rptr1", {27'd0, rptr}, 32'd1);
    tick();
    @(negedge rclk);
    chk("sw_rvalid2", {31'd0, rvalid}, 32'd1);
    tick();
    @(negedge rclk);
    chk("sw_rvalid3", {31'd0, rvalid}, 32'd0);

    // Streaming a full FIFO
    do_reset();
    tick();
    put(16, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      chk("st_ren", {31'd0, ren}, {31'd0, c < 16});
      chk("st_rvalid", {31'd0, rvalid}, {31'd0, c >= 2 && c < 18});
      chk("st_rempty", {31'd0, rempty}, {31'd0, c == 0 || c >= 16});
      chk("st_arempty", {31'd0, arempty}, {31'd0, c == 0 || c >= 15});
      tick();
    end
    chk("st_sb_empty", sb_q.size(), 32'd0);

    // Backpressure
    do_reset();
    rready = 1'b0;
    tick();
    put(8, 8'h40);
    nren = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (ren) nren++;
      chk("bp_rvalid", {31'd0, rvalid}, {31'd0, c >= 2});
      if (c >= 2) chk("bp_hold", {24'd0, rdata}, 32'h40);
      tick();
    end
    chk("bp_nren", nren, 32'd2);
    rready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk);
      chk("bp_stream", {31'd0, rvalid}, 32'd1);
      tick();
    end
    @(negedge rclk);
    chk("bp_end", {31'd0, rvalid}, 32'd0);

    // Pointer wrap
    do_reset();
    put(16, 8'h80);
    drain();
    tick();
    put(14, 8'h90);
    drain();
    wexp[0] = 4'd14;
    wexp[1] = 4'd15;
    wexp[2] = 4'd0;
    wexp[3] = 4'd1;
    tick();
    put(4, 8'hC0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (ren) begin
        if (k < 4) chk("wr_raddr", {28'd0, raddr}, {28'd0, wexp[k]});
        k++;
      end
      tick();
    end
    chk("wr_nren", k, 32'd4);
    chk("wr_rptr", {27'd0, rptr}, 32'd3);
    drain();

    // Reset in the middle of a stalled stream
    do_reset();
    rready = 1'b0;
    tick();
    put(8, 8'h50);
    @(negedge rclk);
    tick();
    @(negedge rclk);
    tick();
    rrst = 1'b1;
    wbin = '0;
    rq2_wptr = '0;
    sb_q.delete();
    tick();
    @(negedge rclk);
    chk("mr_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mr_rptr", {27'd0, rptr}, 32'd0);
    chk("mr_ren", {31'd0, ren}, 32'd0);
    tick();
    rrst = 1'b0;
    rready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      chk("mr_quiet", {31'd0, rvalid}, 32'd0);
      tick();
    end
    put(3, 8'h60);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
